bp_nonsynth_commit_driver: RTL and testbench
============================================

Name: bp_nonsynth_commit_driver

Overview:
Non-synthesizable stimulus source for the core-progress interface: wfi, next-PC and per-cycle instruction-retire strobe. It replaces a core in unit benches of progress monitors such as the watchdog and heartbeat logic. A scripted phase sequence produces, in order:
- normal retirement with an advancing PC,
- a pipeline stall,
- a WFI sleep,
- a self-loop "halt" that retires instructions at a constant PC.

Parameters:
vaddr_width_p, 39, width of npc_o.
cnt_width_p, 32, width of every phase-length field and of instr_cnt_o.
boot_pc_p, 'h0080000000, npc_o value after reset (truncated to vaddr_width_p).
pc_stride_p, 4, npc_o increment per retired instruction in the run phase.

Ports:
clk_i  in  1  clock.
reset_i  in  1  asynchronous, active-high reset.
cfg_v_i  in  1  script valid.
cfg_ready_o  out  1  driver can accept a script.
run_instr_i  in  cnt_width_p  run-phase length, in retired instructions.
stall_cycles_i  in  cnt_width_p  stall-phase length, in cycles.
wfi_cycles_i  in  cnt_width_p  wfi-phase length, in cycles.
spin_instr_i  in  cnt_width_p  self-loop phase length, in retired instructions.
npc_o  out  vaddr_width_p  next PC.
instret_o  out  1  one instruction retired this cycle.
wfi_o  out  1  core is in WFI.
done_o  out  1  script complete.
instr_cnt_o  out  cnt_width_p  total instructions retired since reset.

Behaviour:
- States: e_idle, e_run, e_stall, e_wfi, e_spin, e_done. All state and outputs are registered, with no combinational input-to-output paths except cfg_ready_o, which decodes state only.
- Reset (asynchronous, any time, including mid-script):
  - state = e_idle, npc_o = boot_pc_p, instret_o = 0, wfi_o = 0, done_o = 0, instr_cnt_o = 0, cfg_ready_o = 1.
  - Any in-flight script is discarded.
- cfg_ready_o = 1 in e_idle and e_done, otherwise 0.
- Handshake: a script is accepted on a rising edge where cfg_v_i & cfg_ready_o. On acceptance:
  - all four length fields are latched into phase counters;
  - done_o clears;
  - npc_o and instr_cnt_o are not reset, so scripts chain with a continuous PC.
- Phase order: run -> stall -> wfi -> spin -> done.
  - A phase whose latched length is 0 is skipped.
  - The next state is the first nonzero phase, evaluated in the same cycle. There are no idle bubbles between phases.
  - An all-zero script goes to e_done one cycle after acceptance.
- Latency: the first phase's outputs are visible in the cycle after the accepting edge.
- e_run:
  - instret_o = 1 every cycle, for exactly run_instr cycles.
  - npc_o advances by pc_stride_p at the end of each of those cycles, wrapping modulo 2^vaddr_width_p.
- e_stall: instret_o = 0, wfi_o = 0, npc_o held, for exactly stall_cycles cycles.
- e_wfi: wfi_o = 1, instret_o = 0, npc_o held, for exactly wfi_cycles cycles.
- e_spin: instret_o = 1 every cycle, npc_o held constant, for exactly spin_instr cycles. This models a branch-to-self halt.
- e_done:
  - done_o = 1, instret_o = 0, wfi_o = 0, npc_o held.
  - Remains in e_done until a new script is accepted.
- instr_cnt_o increments by 1 in every cycle with instret_o = 1 and wraps modulo 2^cnt_width_p.
- Phase counters decrement once per phase cycle. A phase exits on the cycle its counter reaches 1.
- Maximum-length fields (all ones) must not overflow the counters.
- cfg_v_i while cfg_ready_o = 0 is ignored. It is neither latched nor queued.
- Simultaneous cfg acceptance and final-phase exit cannot occur, because cfg_ready_o is 0 until e_done is entered.

Test Plan:
- Reset check: assert reset_i asynchronously between edges -> within the same cycle npc_o = 'h0080000000, instret_o = 0, wfi_o = 0, done_o = 0, cfg_ready_o = 1.
- Full script run = 3, stall = 2, wfi = 2, spin = 4:
  - instret_o sequence 1,1,1,0,0,0,0,1,1,1,1, then done_o = 1;
  - npc_o goes boot, +4, +8, then holds at boot+12;
  - wfi_o is high on cycles 6-7 only;
  - instr_cnt_o = 7.
- Zero-skip script run = 0, stall = 5, wfi = 0, spin = 0 -> exactly 5 stall cycles, then done_o = 1; npc_o and instr_cnt_o unchanged.
- All-zero script -> done_o = 1 one cycle after acceptance. A second script run = 2 chained from e_done -> npc_o continues from the prior value; instr_cnt_o accumulates to prior + 2.
- Assert reset_i during the e_wfi phase of the full script -> outputs return to reset values immediately; a new script restarts from boot_pc_p.
- PC wrap: vaddr_width_p = 8, boot_pc_p = 'hF8, run = 3 -> npc_o shows F8, FC, 00, then 04 held.

Source files
------------

// File: rtl/bp_nonsynth_commit_driver.sv
// -----------------------------------------------------------------------------
// bp_nonsynth_commit_driver
//
// Purpose:
//   Scripted stand-in for a core's progress interface (wfi, next PC, retire
//   strobe). It feeds unit benches of progress monitors such as watchdogs and
//   heartbeat logic. One accepted script plays these phases in order:
//     run   - retire one instruction per cycle while the PC advances
//     stall - no retirement, PC held
//     wfi   - core asleep, PC held
//     spin  - retire one instruction per cycle at a fixed PC (branch-to-self)
//     done  - script finished, waiting for the next one
//   A phase with a zero length is skipped. The PC and the retire count carry
//   over from one script to the next, so scripts chain seamlessly.
//
// Ports:
//   clk_i           clock
//   reset_i         asynchronous, active-high reset
//   cfg_v_i         script valid
//   cfg_ready_o     driver can accept a script (idle or done)
//   run_instr_i     run-phase length, in retired instructions
//   stall_cycles_i  stall-phase length, in cycles
//   wfi_cycles_i    wfi-phase length, in cycles
//   spin_instr_i    self-loop phase length, in retired instructions
//   npc_o           next PC
//   instret_o       one instruction retired this cycle
//   wfi_o           core is in WFI
//   done_o          script complete
//   instr_cnt_o     total instructions retired since reset
// -----------------------------------------------------------------------------
module bp_nonsynth_commit_driver #(
    parameter int unsigned vaddr_width_p = 39,
    parameter int unsigned cnt_width_p   = 32,
    parameter logic [63:0] boot_pc_p     = 64'h00_8000_0000,
    parameter int unsigned pc_stride_p   = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     cfg_v_i,
    output logic                     cfg_ready_o,
    input  logic [cnt_width_p-1:0]   run_instr_i,
    input  logic [cnt_width_p-1:0]   stall_cycles_i,
    input  logic [cnt_width_p-1:0]   wfi_cycles_i,
    input  logic [cnt_width_p-1:0]   spin_instr_i,

    output logic [vaddr_width_p-1:0] npc_o,
    output logic                     instret_o,
    output logic                     wfi_o,
    output logic                     done_o,
    output logic [cnt_width_p-1:0]   instr_cnt_o
);

    typedef enum logic [2:0] {
        e_idle,
        e_run,
        e_stall,
        e_wfi,
        e_spin,
        e_done
    } state_e;

    localparam logic [vaddr_width_p-1:0] lp_boot_pc   = boot_pc_p[vaddr_width_p-1:0];
    localparam logic [vaddr_width_p-1:0] lp_pc_stride = vaddr_width_p'(pc_stride_p);
    localparam logic [cnt_width_p-1:0]   lp_cnt_one   = cnt_width_p'(1);

    // Architectural state
    state_e                   r_state;
    logic [cnt_width_p-1:0]   r_run_cnt;
    logic [cnt_width_p-1:0]   r_stall_cnt;
    logic [cnt_width_p-1:0]   r_wfi_cnt;
    logic [cnt_width_p-1:0]   r_spin_cnt;

    // Registered outputs
    logic [vaddr_width_p-1:0] r_npc;
    logic                     r_instret;
    logic                     r_wfi;
    logic                     r_done;
    logic [cnt_width_p-1:0]   r_instr_cnt;

    // Combinational helpers
    logic                     w_accept;
    state_e                   w_next_state;

    // First phase, in script order, whose remaining length is nonzero.
    // Falling through every phase lands in e_done, which is how empty
    // phases are skipped without spending a cycle in them.
    function automatic state_e first_phase(input logic run_nz,
                                           input logic stall_nz,
                                           input logic wfi_nz,
                                           input logic spin_nz);
        if (run_nz)        return e_run;
        else if (stall_nz) return e_stall;
        else if (wfi_nz)   return e_wfi;
        else if (spin_nz)  return e_spin;
        else               return e_done;
    endfunction

    // Ready is a pure decode of the state, so a script offered while a
    // phase is playing is simply dropped rather than queued.
    assign cfg_ready_o = (r_state == e_idle) || (r_state == e_done);
    assign w_accept    = cfg_v_i && cfg_ready_o;

    // Next-state decode. A phase exits in the cycle its counter reads 1,
    // and the following phase is chosen right then, so there is never a
    // bubble cycle between phases.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and
        // no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            e_idle, e_done: begin
                if (w_accept) begin
                    w_next_state = first_phase(|run_instr_i, |stall_cycles_i,
                                               |wfi_cycles_i, |spin_instr_i);
                end
            end
            e_run: begin
                if (r_run_cnt == lp_cnt_one) begin
                    w_next_state = first_phase(1'b0, |r_stall_cnt,
                                               |r_wfi_cnt, |r_spin_cnt);
                end
            end
            e_stall: begin
                if (r_stall_cnt == lp_cnt_one) begin
                    w_next_state = first_phase(1'b0, 1'b0,
                                               |r_wfi_cnt, |r_spin_cnt);
                end
            end
            e_wfi: begin
                if (r_wfi_cnt == lp_cnt_one) begin
                    w_next_state = first_phase(1'b0, 1'b0, 1'b0, |r_spin_cnt);
                end
            end
            e_spin: begin
                if (r_spin_cnt == lp_cnt_one) begin
                    w_next_state = e_done;
                end
            end
            default: w_next_state = e_idle;
        endcase
    end

    // State, phase counters and outputs. Outputs are computed from the
    // next state so they line up with the state they describe, with no
    // combinational path from the script inputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= e_idle;
            r_run_cnt   <= '0;
            r_stall_cnt <= '0;
            r_wfi_cnt   <= '0;
            r_spin_cnt  <= '0;
            r_npc       <= lp_boot_pc;
            r_instret   <= 1'b0;
            r_wfi       <= 1'b0;
            r_done      <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            r_state   <= w_next_state;
            r_instret <= (w_next_state == e_run) || (w_next_state == e_spin);
            r_wfi     <= (w_next_state == e_wfi);
            r_done    <= (w_next_state == e_done);

            // Counters hold the remaining length and count down to 0, so an
            // all-ones length fits without any extra width.
            if (w_accept) begin
                r_run_cnt   <= run_instr_i;
                r_stall_cnt <= stall_cycles_i;
                r_wfi_cnt   <= wfi_cycles_i;
                r_spin_cnt  <= spin_instr_i;
            end else begin
                unique case (r_state)
                    e_run:   r_run_cnt   <= r_run_cnt   - lp_cnt_one;
                    e_stall: r_stall_cnt <= r_stall_cnt - lp_cnt_one;
                    e_wfi:   r_wfi_cnt   <= r_wfi_cnt   - lp_cnt_one;
                    e_spin:  r_spin_cnt  <= r_spin_cnt  - lp_cnt_one;
                    default: ;
                endcase
            end

            // PC moves only across run-phase cycles and wraps naturally at the
            // register width. The spin phase keeps it fixed (branch-to-self).
            if (r_state == e_run) begin
                r_npc <= r_npc + lp_pc_stride;
            end

            // Count each cycle in which the retire strobe is presented.
            if (r_instret) begin
                r_instr_cnt <= r_instr_cnt + lp_cnt_one;
            end
        end
    end

    assign npc_o       = r_npc;
    assign instret_o   = r_instret;
    assign wfi_o       = r_wfi;
    assign done_o      = r_done;
    assign instr_cnt_o = r_instr_cnt;

endmodule

// File: tb/tb_bp_nonsynth_commit_driver.sv
// -----------------------------------------------------------------------------
// tb_bp_nonsynth_commit_driver
//
// Scoreboard bench for the commit driver. The stimulus process issues scripts
// and pushes the hand-computed per-cycle output tuple for every cycle after
// the accepting edge. An independent monitor pops one tuple per falling edge
// and compares it with the DUT. A second instance with an 8-bit PC exercises
// the PC wrap.
// -----------------------------------------------------------------------------
module tb_bp_nonsynth_commit_driver;

    typedef struct packed {
        logic        instret;
        logic        wfi;
        logic        done;
        logic        ready;
        logic [38:0] npc;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        cfg_v_main;
    logic        cfg_v_wrap;
    logic [31:0] run_instr;
    logic [31:0] stall_cycles;
    logic [31:0] wfi_cycles;
    logic [31:0] spin_instr;

    logic        m_ready, m_instret, m_wfi, m_done;
    logic [38:0] m_npc;
    logic [31:0] m_cnt;

    logic        w_ready, w_instret, w_wfi, w_done;
    logic [7:0]  w_npc;
    logic [31:0] w_cnt;

    exp_t q_main[$];
    exp_t q_wrap[$];
    int   n_main;
    int   n_wrap;

    int   checks;
    int   failures;

    localparam logic [38:0] B = 39'h00_8000_0000;

    bp_nonsynth_commit_driver u_main (
        .clk_i          (clk),
        .reset_i        (reset),
        .cfg_v_i        (cfg_v_main),
        .cfg_ready_o    (m_ready),
        .run_instr_i    (run_instr),
        .stall_cycles_i (stall_cycles),
        .wfi_cycles_i   (wfi_cycles),
        .spin_instr_i   (spin_instr),
        .npc_o          (m_npc),
        .instret_o      (m_instret),
        .wfi_o          (m_wfi),
        .done_o         (m_done),
        .instr_cnt_o    (m_cnt)
    );

    bp_nonsynth_commit_driver #(
        .vaddr_width_p (8),
        .cnt_width_p   (32),
        .boot_pc_p     (64'hF8),
        .pc_stride_p   (4)
    ) u_wrap (
        .clk_i          (clk),
        .reset_i        (reset),
        .cfg_v_i        (cfg_v_wrap),
        .cfg_ready_o    (w_ready),
        .run_instr_i    (run_instr),
        .stall_cycles_i (stall_cycles),
        .wfi_cycles_i   (wfi_cycles),
        .spin_instr_i   (spin_instr),
        .npc_o          (w_npc),
        .instret_o      (w_instret),
        .wfi_o          (w_wfi),
        .done_o         (w_done),
        .instr_cnt_o    (w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_main(input logic i, input logic w, input logic d,
                             input logic r, input logic [38:0] npc,
                             input logic [31:0] cnt);
        exp_t e;
        e = '{instret: i, wfi: w, done: d, ready: r, npc: npc, cnt: cnt};
        q_main.push_back(e);
    endtask

    task automatic push_wrap(input logic i, input logic w, input logic d,
                             input logic r, input logic [7:0] npc,
                             input logic [31:0] cnt);
        exp_t e;
        e = '{instret: i, wfi: w, done: d, ready: r, npc: {31'd0, npc}, cnt: cnt};
        q_wrap.push_back(e);
    endtask

    // Monitor: one expected tuple per cycle while anything is outstanding.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (q_main.size() > 0) begin
            e = q_main.pop_front();
            a = '{instret: m_instret, wfi: m_wfi, done: m_done, ready: m_ready,
                  npc: m_npc, cnt: m_cnt};
            n_main++;
            check($sformatf("main_cycle%0d", n_main), 128'(a), 128'(e));
        end
        if (q_wrap.size() > 0) begin
            e = q_wrap.pop_front();
            a = '{instret: w_instret, wfi: w_wfi, done: w_done, ready: w_ready,
                  npc: {31'd0, w_npc}, cnt: w_cnt};
            n_wrap++;
            check($sformatf("wrap_cycle%0d", n_wrap), 128'(a), 128'(e));
        end
    end

    // Called at posedge+1; presents a script for exactly one edge.
    task automatic start_script(input bit to_wrap, input logic [31:0] r,
                                input logic [31:0] s, input logic [31:0] w,
                                input logic [31:0] sp);
        check(to_wrap ? "wrap_ready_before_cfg" : "main_ready_before_cfg",
              128'(to_wrap ? w_ready : m_ready), 128'(1));
        run_instr    = r;
        stall_cycles = s;
        wfi_cycles   = w;
        spin_instr   = sp;
        if (to_wrap) cfg_v_wrap = 1'b1;
        else         cfg_v_main = 1'b1;
        @(posedge clk);
        #1;
        cfg_v_main = 1'b0;
        cfg_v_wrap = 1'b0;
    endtask

    // Bounded wait until the monitor has consumed every expected tuple.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q_main.size() != 0 || q_wrap.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_drain"}, 128'(q_main.size() + q_wrap.size()), 128'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_npc"},     128'(m_npc),     128'(B));
        check({tag, "_instret"}, 128'(m_instret), 128'(0));
        check({tag, "_wfi"},     128'(m_wfi),     128'(0));
        check({tag, "_done"},    128'(m_done),    128'(0));
        check({tag, "_ready"},   128'(m_ready),   128'(1));
        check({tag, "_cnt"},     128'(m_cnt),     128'(0));
        check({tag, "_wrap_npc"}, 128'(w_npc),    128'(8'hF8));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        n_main       = 0;
        n_wrap       = 0;
        reset        = 1'b0;
        cfg_v_main   = 1'b0;
        cfg_v_wrap   = 1'b0;
        run_instr    = '0;
        stall_cycles = '0;
        wfi_cycles   = '0;
        spin_instr   = '0;

        // Asynchronous reset between edges, before any clock edge.
        #2 reset = 1'b1;
        #1 check_reset_values("rst_async");
        #14 reset = 1'b0;
        @(posedge clk);
        #1 check_reset_values("rst_idle");

        // Full script: run 3, stall 2, wfi 2, spin 4.
        start_script(1'b0, 32'd3, 32'd2, 32'd2, 32'd4);
        push_main(1, 0, 0, 0, B + 39'd0,  32'd0);
        push_main(1, 0, 0, 0, B + 39'd4,  32'd1);
        push_main(1, 0, 0, 0, B + 39'd8,  32'd2);
        push_main(0, 0, 0, 0, B + 39'd12, 32'd3);
        push_main(0, 0, 0, 0, B + 39'd12, 32'd3);
        push_main(0, 1, 0, 0, B + 39'd12, 32'd3);
        push_main(0, 1, 0, 0, B + 39'd12, 32'd3);
        push_main(1, 0, 0, 0, B + 39'd12, 32'd3);
        push_main(1, 0, 0, 0, B + 39'd12, 32'd4);
        push_main(1, 0, 0, 0, B + 39'd12, 32'd5);
        push_main(1, 0, 0, 0, B + 39'd12, 32'd6);
        push_main(0, 0, 1, 1, B + 39'd12, 32'd7);
        // A script offered while busy must be ignored entirely.
        @(posedge clk);
        #1;
        run_instr  = 32'd9;
        cfg_v_main = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        cfg_v_main = 1'b0;
        drain("full");

        // Zero-skip script: only 5 stall cycles.
        start_script(1'b0, 32'd0, 32'd5, 32'd0, 32'd0);
        repeat (5) push_main(0, 0, 0, 0, B + 39'd12, 32'd7);
        push_main(0, 0, 1, 1, B + 39'd12, 32'd7);
        drain("skip");

        // All-zero script goes straight to done.
        start_script(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        push_main(0, 0, 1, 1, B + 39'd12, 32'd7);
        drain("zero");

        // Chained script continues the PC and the retire count.
        start_script(1'b0, 32'd2, 32'd0, 32'd0, 32'd0);
        push_main(1, 0, 0, 0, B + 39'd12, 32'd7);
        push_main(1, 0, 0, 0, B + 39'd16, 32'd8);
        push_main(0, 0, 1, 1, B + 39'd20, 32'd9);
        drain("chain");

        // Full script again, interrupted by reset in its second wfi cycle.
        start_script(1'b0, 32'd3, 32'd2, 32'd2, 32'd4);
        push_main(1, 0, 0, 0, B + 39'd20, 32'd9);
        push_main(1, 0, 0, 0, B + 39'd24, 32'd10);
        push_main(1, 0, 0, 0, B + 39'd28, 32'd11);
        push_main(0, 0, 0, 0, B + 39'd32, 32'd12);
        push_main(0, 0, 0, 0, B + 39'd32, 32'd12);
        push_main(0, 1, 0, 0, B + 39'd32, 32'd12);
        drain("pre_reset");
        check("mid_wfi_before_reset", 128'(m_wfi), 128'(1));
        #1 reset = 1'b1;
        #1 check_reset_values("rst_mid_wfi");
        #4 reset = 1'b0;
        @(posedge clk);
        #1;

        // Restart from the boot PC after the reset.
        start_script(1'b0, 32'd1, 32'd0, 32'd0, 32'd0);
        push_main(1, 0, 0, 0, B,          32'd0);
        push_main(0, 0, 1, 1, B + 39'd4,  32'd1);
        drain("restart");

        // PC wrap on the 8-bit instance.
        start_script(1'b1, 32'd3, 32'd0, 32'd0, 32'd0);
        push_wrap(1, 0, 0, 0, 8'hF8, 32'd0);
        push_wrap(1, 0, 0, 0, 8'hFC, 32'd1);
        push_wrap(1, 0, 0, 0, 8'h00, 32'd2);
        push_wrap(0, 0, 1, 1, 8'h04, 32'd3);
        drain("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
